// File: rtl/debounce_en_pkg.sv
// debounce_en_pkg: state encoding and parameter defaults shared by the debouncer files.
// Build option: DEBOUNCE_EN_FALL_PULSE_EN adds the fall strobe port.
package debounce_en_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_RISING  = 2'd1,
        S_HIGH    = 2'd2,
        S_FALLING = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 16;

    // Counter width for a qualification length; never below one bit.
    function automatic int cnt_width(input int stable_cnt);
        return (stable_cnt < 2) ? 1 : $clog2(stable_cnt);
    endfunction

endpackage

// File: rtl/debounce_en_sync_chain.sv
// sync_chain: DEPTH-flop synchroniser for an asynchronous single-bit input.
// Every stage clears to 0 on asynchronous active-low reset.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_chain <= '0;
        else
            r_chain <= {r_chain[DEPTH-2:0], i_d};
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/debounce_en.sv
// debounce_en: tick-qualified switch debouncer with registered level and edge strobes.
// Build option: DEBOUNCE_EN_FALL_PULSE_EN adds the fall strobe port and register.
module debounce_en
    import debounce_en_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic debounce_en_cport_clk,
    input  logic debounce_en_cport_rst_n,
    input  logic debounce_en_cport_tick,
    input  logic debounce_en_iport_raw,
`ifdef DEBOUNCE_EN_FALL_PULSE_EN
    output logic debounce_en_oport_fall,
`endif
    output logic debounce_en_oport_level,
    output logic debounce_en_oport_rise
);

    localparam int             CW       = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);

    logic          w_syn;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_level, r_rise;
    logic          w_done;

    sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
        .i_clk   (debounce_en_cport_clk),
        .i_rst_n (debounce_en_cport_rst_n),
        .i_d     (debounce_en_iport_raw),
        .o_q     (w_syn)
    );

    assign w_done = debounce_en_cport_tick && (r_cnt == CNT_LAST);

    // Bounce rejection outranks counting; every transition clears the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_LOW: begin
                if (w_syn) begin
                    w_state_nxt = S_RISING;
                    w_cnt_nxt   = '0;
                end
            end
            S_RISING: begin
                if (!w_syn) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (debounce_en_cport_tick) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!w_syn) begin
                    w_state_nxt = S_FALLING;
                    w_cnt_nxt   = '0;
                end
            end
            S_FALLING: begin
                if (w_syn) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (w_done) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (debounce_en_cport_tick) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge debounce_en_cport_clk or negedge debounce_en_cport_rst_n) begin
        if (!debounce_en_cport_rst_n) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_FALLING);
            r_rise  <= (r_state == S_RISING) && (w_state_nxt == S_HIGH);
        end
    end

`ifdef DEBOUNCE_EN_FALL_PULSE_EN
    logic r_fall;

    always_ff @(posedge debounce_en_cport_clk or negedge debounce_en_cport_rst_n) begin
        if (!debounce_en_cport_rst_n)
            r_fall <= 1'b0;
        else
            r_fall <= (r_state == S_FALLING) && (w_state_nxt == S_LOW);
    end

    assign debounce_en_oport_fall = r_fall;
`endif

    assign debounce_en_oport_level = r_level;
    assign debounce_en_oport_rise  = r_rise;

endmodule
